// File: rtl/half_div_ctrl.sv
// -----------------------------------------------------------------------------
// half_div_ctrl
//   Sequencer/configurator for a half-integer clock divider (ratio in half
//   steps, N2 = 2*ratio, e.g. N2=9 means /4.5). It starts and stops the
//   divider and takes ratio changes over a valid/ready handshake. A change is
//   applied only at a divider period boundary (div_wrap), followed by a
//   forced low gap on div_en, so the divided clock never glitches.
//
// Ports
//   clk        in   system clock, shared with the divider
//   rst        in   synchronous reset, active-high
//   run_en     in   level: 1 = divider should run
//   cfg_valid  in   new ratio offered
//   cfg_n2     in   offered ratio (N2 encoding)
//   cfg_ready  out  ratio accepted on cfg_valid & cfg_ready
//   div_wrap   in   one-cycle pulse from the divider at the end of a period
//   div_en     out  divider enable (registered)
//   div_load   out  one-cycle pulse: divider loads div_n2, clears counters
//   div_n2     out  ratio presented to the divider (valid with div_load)
//   active_n2  out  ratio currently running (DEF_N2 until the first load)
//   busy       out  1 while switching (any state other than IDLE/RUN)
//   cfg_err    out  one-cycle pulse: accepted cfg_n2 < MIN_N2, ignored
//   tmo_err    out  one-cycle pulse: no div_wrap seen within TMO cycles
//   state_dbg  out  current FSM state, for checkers and debug
//
// Handshake: a transfer happens on every rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready depends only on the current state (1 in
// IDLE and RUN), never on cfg_valid. The producer must hold cfg_n2 stable
// while cfg_valid is 1 and cfg_ready is 0.
// -----------------------------------------------------------------------------
module half_div_ctrl #(
    parameter int unsigned W      = 5,
    parameter int unsigned MIN_N2 = 3,
    parameter int unsigned DEF_N2 = 9,
    parameter int unsigned GAP    = 2,
    parameter int unsigned TMO    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_n2,
    output logic         cfg_ready,
    input  logic         div_wrap,
    output logic         div_en,
    output logic         div_load,
    output logic [W-1:0] div_n2,
    output logic [W-1:0] active_n2,
    output logic         busy,
    output logic         cfg_err,
    output logic         tmo_err,
    output logic [2:0]   state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int unsigned TMO_CW = $clog2(TMO + 1);
    localparam int unsigned GAP_CW = $clog2(GAP + 1);

    localparam logic [W-1:0]      MIN_N2_W = W'(MIN_N2);
    localparam logic [W-1:0]      DEF_N2_W = W'(DEF_N2);
    localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TMO - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [W-1:0]      shadow;
    logic [W-1:0]      shadow_nxt;
    logic [TMO_CW-1:0] tmo_cnt;
    logic [GAP_CW-1:0] gap_cnt;
    logic              cfg_accept;
    logic              cfg_legal;
    logic              tmo_hit;

    assign cfg_ready = (state == S_IDLE) || (state == S_RUN);
    assign busy      = !cfg_ready;
    assign state_dbg = state;

    always_comb begin
        cfg_accept = cfg_valid && cfg_ready;
        cfg_legal  = (cfg_n2 >= MIN_N2_W);

        shadow_nxt = shadow;
        if (cfg_accept && cfg_legal) begin
            shadow_nxt = cfg_n2;
        end

        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_en) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // div_wrap is ignored here: a wrap on the same cycle as the
                // switch request is not treated as the boundary.
                if (!run_en) begin
                    state_nxt = S_WAIT;
                end else if (cfg_accept && cfg_legal && (cfg_n2 != active_n2)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real boundary wins over a coincident timeout.
                if (div_wrap) begin
                    state_nxt = S_GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_GAP;
                    tmo_hit   = 1'b1;
                end
            end
            S_GAP: begin
                // run_en is only looked at on the last gap cycle.
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = run_en ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shadow    <= DEF_N2_W;
            div_en    <= 1'b0;
            div_load  <= 1'b0;
            div_n2    <= DEF_N2_W;
            active_n2 <= DEF_N2_W;
            cfg_err   <= 1'b0;
            tmo_err   <= 1'b0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            cfg_err  <= cfg_accept && !cfg_legal;
            tmo_err  <= tmo_hit;
            // Outputs are decoded from the next state so they line up with
            // the state they belong to, without a combinational path out.
            div_en   <= (state_nxt == S_RUN) || (state_nxt == S_WAIT);
            div_load <= (state_nxt == S_LOAD);

            // shadow_nxt covers a ratio accepted in IDLE on the same cycle
            // that run_en starts the divider.
            if (state_nxt == S_LOAD) begin
                div_n2 <= shadow_nxt;
            end
            if (state == S_LOAD) begin
                active_n2 <= div_n2;
            end

            if ((state == S_WAIT) && (state_nxt == S_WAIT)) begin
                if (tmo_cnt != TMO_LAST) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end

            if ((state == S_GAP) && (state_nxt == S_GAP)) begin
                if (gap_cnt != GAP_LAST) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_half_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_half_div_ctrl
//   Directed bench for half_div_ctrl. A behavioural model describes the
//   controller in terms of "divider enabled", "seeking a boundary",
//   "gap cycles left" and "load pending", and one compare process checks
//   every output against it each cycle. Directed scenarios add literal
//   expectations at hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_half_div_ctrl;

    localparam int W      = 5;
    localparam int MIN_N2 = 3;
    localparam int DEF_N2 = 9;
    localparam int GAP    = 2;
    localparam int TMO    = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         run_en    = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_n2    = '0;
    logic         div_wrap  = 1'b0;
    logic         cfg_ready;
    logic         div_en;
    logic         div_load;
    logic [W-1:0] div_n2;
    logic [W-1:0] active_n2;
    logic         busy;
    logic         cfg_err;
    logic         tmo_err;
    logic [2:0]   state_dbg;

    half_div_ctrl #(
        .W      (W),
        .MIN_N2 (MIN_N2),
        .DEF_N2 (DEF_N2),
        .GAP    (GAP),
        .TMO    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_n2    (cfg_n2),
        .cfg_ready (cfg_ready),
        .div_wrap  (div_wrap),
        .div_en    (div_en),
        .div_load  (div_load),
        .div_n2    (div_n2),
        .active_n2 (active_n2),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .tmo_err   (tmo_err),
        .state_dbg (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    logic         model_valid = 1'b0;
    logic         m_enabled;
    logic         m_seek;
    logic         m_load_now;
    int           m_gap_left;
    int           m_age;
    logic [W-1:0] m_shadow;
    logic [W-1:0] m_active;
    logic [W-1:0] m_div_n2;
    logic         m_cfg_err;
    logic         m_tmo_err;
    logic         m_accept;
    logic         m_legal;
    logic         m_start;

    function automatic logic model_idle();
        return !m_enabled && !m_load_now && (m_gap_left == 0) && !m_seek;
    endfunction

    function automatic logic model_ready();
        return model_idle() || (m_enabled && !m_seek);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            m_enabled   = 1'b0;
            m_seek      = 1'b0;
            m_load_now  = 1'b0;
            m_gap_left  = 0;
            m_age       = 0;
            m_shadow    = W'(DEF_N2);
            m_active    = W'(DEF_N2);
            m_div_n2    = W'(DEF_N2);
            m_cfg_err   = 1'b0;
            m_tmo_err   = 1'b0;
        end else if (model_valid) begin
            m_accept  = cfg_valid && model_ready();
            m_legal   = (int'(cfg_n2) >= MIN_N2);
            m_cfg_err = m_accept && !m_legal;
            m_tmo_err = 1'b0;
            m_start   = 1'b0;
            if (m_load_now) begin
                // divider loaded last cycle: it now runs the loaded ratio
                m_load_now = 1'b0;
                m_enabled  = 1'b1;
                m_active   = m_div_n2;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
                if (m_gap_left == 0 && run_en) m_start = 1'b1;
            end else if (m_seek) begin
                m_age++;
                if (div_wrap || m_age == TMO) begin
                    m_tmo_err  = !div_wrap;
                    m_seek     = 1'b0;
                    m_enabled  = 1'b0;
                    m_gap_left = GAP;
                end
            end else if (m_enabled) begin
                if (!run_en || (m_accept && m_legal && cfg_n2 != m_active)) begin
                    m_seek = 1'b1;
                    m_age  = 0;
                end
            end else if (run_en) begin
                m_start = 1'b1;
            end
            if (m_accept && m_legal) m_shadow = cfg_n2;
            if (m_start) begin
                m_load_now = 1'b1;
                m_div_n2   = m_shadow;
            end
        end
    end

    // scoreboard: one compare per output per cycle, away from the edge
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
            check("busy",      32'(busy),      32'(!model_ready()));
            check("div_en",    32'(div_en),    32'(m_enabled));
            check("div_load",  32'(div_load),  32'(m_load_now));
            check("div_n2",    32'(div_n2),    32'(m_div_n2));
            check("active_n2", 32'(active_n2), 32'(m_active));
            check("cfg_err",   32'(cfg_err),   32'(m_cfg_err));
            check("tmo_err",   32'(tmo_err),   32'(m_tmo_err));
        end
    end

    // ---------------------------------------------------------------------
    // driver tasks (inputs change on the falling edge)
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [W-1:0] v);
        cfg_valid = 1'b1;
        cfg_n2    = v;
    endtask

    task automatic drop_offer();
        cfg_valid = 1'b0;
        cfg_n2    = W'($urandom_range(0, 31));
    endtask

    task automatic wrap_pulse();
        div_wrap = 1'b1;
        tick(1);
        div_wrap = 1'b0;
    endtask

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, start, first load with DEF_N2
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst_div_n2",    32'(div_n2),    32'd9);
        check("rst_active_n2", 32'(active_n2), 32'd9);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        tick(2);
        run_en = 1'b1;
        tick(1);
        check("t1_load",    32'(div_load), 32'd1);
        check("t1_load_n2", 32'(div_n2),   32'd9);
        check("t1_en_lat",  32'(div_en),   32'd0);
        tick(1);
        check("t1_en",      32'(div_en),    32'd1);
        check("t1_active",  32'(active_n2), 32'd9);
        tick(4);

        // 2: change to 7, boundary from div_wrap
        offer(5'd7);
        tick(1);
        drop_offer();
        check("t2_ready_low", 32'(cfg_ready), 32'd0);
        check("t2_busy",      32'(busy),      32'd1);
        run_en = 1'b0;   // toggling run_en while waiting is ignored
        tick(2);
        run_en = 1'b1;
        tick(1);
        wrap_pulse();
        check("t2_gap0_en", 32'(div_en), 32'd0);
        tick(1);
        check("t2_gap1_en",   32'(div_en),   32'd0);
        check("t2_gap1_load", 32'(div_load), 32'd0);
        tick(1);
        check("t2_load",    32'(div_load), 32'd1);
        check("t2_load_n2", 32'(div_n2),   32'd7);
        tick(1);
        check("t2_active", 32'(active_n2), 32'd7);
        check("t2_en",     32'(div_en),    32'd1);
        tick(3);

        // 3: illegal ratio is rejected, divider keeps running
        offer(5'd2);
        tick(1);
        drop_offer();
        check("t3_cfg_err", 32'(cfg_err),   32'd1);
        check("t3_ready",   32'(cfg_ready), 32'd1);
        check("t3_active",  32'(active_n2), 32'd7);
        tick(1);
        check("t3_err_pulse", 32'(cfg_err),  32'd0);
        check("t3_no_load",   32'(div_load), 32'd0);
        // same ratio as running: accepted, no switch
        offer(5'd7);
        tick(1);
        drop_offer();
        check("t3_same_busy", 32'(busy), 32'd0);
        tick(2);

        // 4: new ratio and stop on the same cycle, restart later
        offer(5'd11);
        run_en = 1'b0;
        tick(1);
        drop_offer();
        check("t4_busy", 32'(busy),   32'd1);
        check("t4_en",   32'(div_en), 32'd1);
        tick(2);
        wrap_pulse();
        tick(2);
        check("t4_idle_ready", 32'(cfg_ready), 32'd1);
        check("t4_idle_en",    32'(div_en),    32'd0);
        check("t4_idle_load",  32'(div_load),  32'd0);
        check("t4_active",     32'(active_n2), 32'd7);
        tick(3);
        run_en = 1'b1;
        tick(1);
        check("t4_load",    32'(div_load), 32'd1);
        check("t4_load_n2", 32'(div_n2),   32'd11);
        tick(1);
        check("t4_active11", 32'(active_n2), 32'd11);
        tick(2);

        // 5: wrap coincident with the switch request is not a boundary;
        //    no later wrap, so the timeout forces the switch
        offer(5'd13);
        div_wrap = 1'b1;
        tick(1);
        drop_offer();
        div_wrap = 1'b0;
        tick(TMO - 1);
        check("t5_pre_tmo_err", 32'(tmo_err), 32'd0);
        check("t5_pre_tmo_en",  32'(div_en),  32'd1);
        tick(1);
        check("t5_tmo_err", 32'(tmo_err), 32'd1);
        check("t5_tmo_en",  32'(div_en),  32'd0);
        tick(1);
        check("t5_tmo_pulse", 32'(tmo_err), 32'd0);
        tick(1);
        check("t5_load",    32'(div_load), 32'd1);
        check("t5_load_n2", 32'(div_n2),   32'd13);
        tick(3);

        // 6: reset in the middle of the gap
        offer(5'd5);
        tick(1);
        drop_offer();
        tick(1);
        wrap_pulse();
        rst    = 1'b1;
        run_en = 1'b0;
        tick(1);
        rst = 1'b0;
        check("t6_en",     32'(div_en),    32'd0);
        check("t6_load",   32'(div_load),  32'd0);
        check("t6_div_n2", 32'(div_n2),    32'd9);
        check("t6_active", 32'(active_n2), 32'd9);
        check("t6_ready",  32'(cfg_ready), 32'd1);
        check("t6_busy",   32'(busy),      32'd0);
        tick(2);
        run_en = 1'b1;
        tick(1);
        check("t6_restart_n2", 32'(div_n2), 32'd9);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
